// File: rtl/data_mem_ctrl_pkg.sv
// Shared types, widths and helpers for the LSU-to-data-SRAM sequencer.
package data_mem_ctrl_pkg;

    localparam int unsigned ADDR_W          = 64;
    localparam int unsigned DATA_W          = 64;
    localparam int unsigned SEL_W           = 8;
    localparam int unsigned SIZE_W          = 4;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // One-hot bit positions inside req_size
    localparam int unsigned SIZE_BYTE  = 0;
    localparam int unsigned SIZE_HALF  = 1;
    localparam int unsigned SIZE_WORD  = 2;
    localparam int unsigned SIZE_DWORD = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        size_e             size;
        logic              is_unsigned;
    } req_t;

    // Narrowest set bit wins; an all-zero size means a full dword
    function automatic size_e decode_size(input logic [SIZE_W-1:0] s);
        if (s[SIZE_BYTE])      return SZ_B;
        else if (s[SIZE_HALF]) return SZ_H;
        else if (s[SIZE_WORD]) return SZ_W;
        else                   return SZ_D;
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [2:0] off);
        case (sz)
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// Shifts the read dword down to the access offset, then selects and sign/zero-extends by size.
module data_mem_ctrl_load_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        offset,
    input  size_e             size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data_c
);

    logic [DATA_W-1:0] shifted;
    logic              sx;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        sx      = 1'b0;
        data_c  = shifted;
        case (size)
            SZ_B: begin
                sx     = ~is_unsigned & shifted[7];
                data_c = {{56{sx}}, shifted[7:0]};
            end
            SZ_H: begin
                sx     = ~is_unsigned & shifted[15];
                data_c = {{48{sx}}, shifted[15:0]};
            end
            SZ_W: begin
                sx     = ~is_unsigned & shifted[31];
                data_c = {{32{sx}}, shifted[31:0]};
            end
            default: data_c = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage sequencer: one LSU access at a time onto a req/gnt/rvalid SRAM bus with timeout.
// Optional build macro MISALIGN_CHECK_EN rejects misaligned half/word/dword accesses in IDLE.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [SIZE_W-1:0] req_size,
    input  logic              req_unsigned,
    output logic              stallreq,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_e            state;
    req_t              lat;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] align_c;
    logic              misalign_c;
    logic              timeout_c;
    logic              done_c;

    data_mem_ctrl_load_align u_load_align (
        .rdata       (bus_rdata),
        .offset      (lat.addr[2:0]),
        .size        (lat.size),
        .is_unsigned (lat.is_unsigned),
        .data_c      (align_c)
    );

`ifdef MISALIGN_CHECK_EN
    assign misalign_c = misaligned(decode_size(req_size), req_addr[2:0]);
`else
    assign misalign_c = 1'b0;
`endif

    assign timeout_c = (cnt == CNT_W'(TIMEOUT - 1));
    // Completion needs the grant in REQ; in WAIT the data phase alone finishes it
    assign done_c    = (state == ST_REQ) ? (bus_gnt & bus_rvalid) : bus_rvalid;

    assign stallreq  = ((state == ST_IDLE) & req_valid) | (state == ST_REQ) | (state == ST_WAIT);

    assign bus_we    = lat.we;
    assign bus_sel   = lat.sel;
    assign bus_addr  = {lat.addr[ADDR_W-1:3], 3'b000};
    assign bus_wdata = lat.wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat        <= '0;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            bus_req    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat <= '{we:          req_we,
                                 sel:         req_we ? req_sel : '0,
                                 addr:        req_addr,
                                 wdata:       req_wdata,
                                 size:        decode_size(req_size),
                                 is_unsigned: req_unsigned};
                        req_ready <= 1'b0;
                        if (misalign_c) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state   <= ST_REQ;
                            bus_req <= 1'b1;
                            cnt     <= '0;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (timeout_c) begin
                        state      <= ST_DONE;
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else if (done_c) begin
                        state      <= ST_DONE;
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= lat.we ? '0 : align_c;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if ((state == ST_REQ) && bus_gnt) begin
                            state   <= ST_WAIT;
                            bus_req <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    bus_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed spec cases plus randomized loads/stores.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_sel;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_size;
    logic        req_unsigned;
    logic        stallreq;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_sel;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;

    data_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_sel      (req_sel),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .stallreq     (stallreq),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_sel      (bus_sel),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_gnt      (bus_gnt),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got rdata 0x%016h err %0b with nothing outstanding",
                         resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    // Reference: value starts at byte offset, keep 2^sz bytes, extend unless unsigned or dword
    function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] addr,
                                               input int sz, input logic uns);
        int          nbits;
        logic [63:0] v;
        logic [63:0] mask;
        nbits = 8 << sz;
        v     = rdata >> (8 * int'(addr[2:0]));
        if (nbits == 64) return v;
        mask = (64'd1 << nbits) - 64'd1;
        v    = v & mask;
        if (!uns && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic model_misaligned(input logic [63:0] addr, input int sz);
`ifdef MISALIGN_CHECK_EN
        return (int'(addr[2:0]) % (1 << sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
    endtask

    // sz: 0..3 = byte..dword one-hot, 4 = all-zero encoding (behaves as dword)
    task automatic access(input logic we, input int sz, input logic [63:0] addr, input logic uns,
                          input logic [63:0] wdata, input logic [63:0] rdata,
                          input int gdly, input int rdly, input logic same);
        int          eff;
        logic [15:0] sel16;
        logic        mis;
        exp_t        e;
        eff   = (sz == 4) ? 3 : sz;
        sel16 = ((16'd1 << (1 << eff)) - 16'd1) << addr[2:0];
        mis   = model_misaligned(addr, eff);
        wait_ready();
        e.err   = mis;
        e.rdata = (mis || we) ? 64'd0 : model_load(rdata, addr, eff, uns);
        sb.push_back(e);
        req_valid    = 1'b1;
        req_we       = we;
        req_sel      = sel16[7:0];
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = (sz == 4) ? 4'd0 : 4'(1 << sz);
        req_unsigned = uns;
        #1;
        check("stall_accept", 64'(stallreq), 64'd1);
        @(negedge clk);
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};
        req_size     = 4'($urandom);
        req_unsigned = 1'($urandom);
        if (mis) begin
            check("mis_no_bus_req", 64'(bus_req), 64'd0);
            check("mis_resp_timing", 64'(resp_valid), 64'd1);
            check("mis_stall_low", 64'(stallreq), 64'd0);
            @(negedge clk);
            return;
        end
        check("bus_req_issue", 64'(bus_req), 64'd1);
        check("bus_addr", bus_addr, {addr[63:3], 3'b000});
        check("bus_we", 64'(bus_we), 64'(we));
        check("bus_sel", 64'(bus_sel), we ? 64'(sel16[7:0]) : 64'd0);
        if (we) check("bus_wdata", bus_wdata, wdata);
        for (int i = 0; i < gdly; i++) begin
            bus_rvalid = 1'($urandom);
            @(negedge clk);
            check("bus_req_held", 64'(bus_req), 64'd1);
        end
        bus_gnt    = 1'b1;
        bus_rvalid = same;
        bus_rdata  = same ? rdata : {$urandom, $urandom};
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        if (!same) begin
            check("wait_bus_req_low", 64'(bus_req), 64'd0);
            for (int i = 0; i < rdly; i++) begin
                bus_gnt = 1'($urandom);
                @(negedge clk);
                check("wait_stall", 64'(stallreq), 64'd1);
            end
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata  = rdata;
            @(negedge clk);
            bus_rvalid = 1'b0;
        end
        bus_rdata = {$urandom, $urandom};
        check("resp_timing", 64'(resp_valid), 64'd1);
        check("done_stall_low", 64'(stallreq), 64'd0);
        @(negedge clk);
    endtask

    // No grant ever, or a grant followed by a data phase landing on the timeout cycle
    task automatic timeout_test(input logic late_rvalid);
        int   k;
        exp_t e;
        wait_ready();
        e.rdata = 64'd0;
        e.err   = 1'b1;
        sb.push_back(e);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_sel      = 8'h00;
        req_addr     = 64'h3000;
        req_size     = 4'b1000;
        req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        k         = 1;
        bus_gnt   = late_rvalid;
        bus_rdata = 64'h0123_4567_89AB_CDEF;
        while (!resp_valid && k < 300) begin
            @(negedge clk);
            k++;
            bus_gnt    = 1'b0;
            bus_rvalid = (late_rvalid && k == 255);
        end
        bus_rvalid = 1'b0;
        check(late_rvalid ? "timeout_late_latency" : "timeout_latency", 64'(k), 64'd256);
        check("timeout_bus_req_low", 64'(bus_req), 64'd0);
        @(negedge clk);
        check("timeout_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic idle_noise();
        bus_gnt    = 1'($urandom);
        bus_rvalid = 1'($urandom);
        bus_rdata  = {$urandom, $urandom};
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_sel      = 8'h00;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;
        req_size     = 4'd0;
        req_unsigned = 1'b0;
        bus_gnt      = 1'b0;
        bus_rvalid   = 1'b0;
        bus_rdata    = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_bus_addr", bus_addr, 64'd0);
        check("rst_stall", 64'(stallreq), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        access(1'b0, 0, 64'h1003, 1'b0, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b1);
        access(1'b0, 2, 64'h1004, 1'b1, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 4, 1'b0);
        access(1'b1, 3, 64'h2000, 1'b0, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 1'b0);
        access(1'b0, 2, 64'h1002, 1'b0, 64'd0, 64'hAAAA_5555_CCCC_3333, 0, 1, 1'b0);
        access(1'b0, 4, 64'h4008, 1'b1, 64'd0, 64'h8877_6655_4433_2211, 0, 0, 1'b1);
        idle_noise();
        timeout_test(1'b0);
        timeout_test(1'b1);

        // Reset while waiting for the data phase; the late rvalid must be dropped
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 64'h5000;
        req_size  = 4'b0100;
        @(negedge clk);
        req_valid = 1'b0;
        bus_gnt   = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 64'hFEED_FACE_CAFE_BABE;
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        check("rst_mid_bus_req", 64'(bus_req), 64'd0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        check("rst_mid_no_resp", 64'(resp_valid), 64'd0);
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            access(1'($urandom), int'($urandom_range(0, 4)), {$urandom, $urandom},
                   1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 1) == 1) idle_noise();
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
